rr_arb16: RTL and testbench

- Round-robin scheduler that shares one 16-way decoded resource among 16 requesters.
- Picks one requester and drives its 4-bit index W into the decoder select. Also produces the matching registered one-hot grant Y.
- Bounds each tenure with a hold-cycle limit.
- Enable uses the decoder's active-low convention: Enable=0 means operate.

---
 rtl/rr_arb16.sv | 115 +++++++++++
 tb/tb_rr_arb16.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb16.sv
`default_nettype none
// ============================================================================
// Module  : rr_arb16
// Brief   : Round-robin arbiter for 16 requesters sharing one decoded resource,
//           with active-low enable and a per-tenure hold-cycle limit.
// Revision: 1.0 - initial release
// ============================================================================
module rr_arb16 #(
    parameter int N_REQ    = 16,
    parameter int MAX_HOLD = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Enable,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [3:0]       W,
    output logic [0:N_REQ-1] Y,
    output logic             valid,
    output logic             timeout
);

    localparam logic [7:0] c_hold_last = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [3:0]         r_ptr;
    logic [7:0]         r_hold;
    logic [3:0]         r_w;
    logic [0:N_REQ-1]   r_y;
    logic               r_valid;
    logic               r_timeout;

    logic               w_found;
    logic [3:0]         w_pick;
    logic [3:0]         w_idx;
    logic [0:N_REQ-1]   w_onehot;
    logic               w_withdraw;
    logic               w_hold_exp;
    logic               w_release;
    logic               w_advance;

    // Scan starting at the priority pointer; 4-bit index arithmetic wraps for free.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = r_ptr + 4'(k);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_onehot         = '0;
        w_onehot[w_pick] = 1'b1;
    end

    assign w_withdraw = !req[r_w];
    assign w_hold_exp = (r_hold == c_hold_last);
    assign w_advance  = done || w_withdraw || w_hold_exp;
    assign w_release  = w_advance || Enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_hold    <= '0;
            r_w       <= '0;
            r_y       <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!Enable && w_found) begin
                        r_w     <= w_pick;
                        r_y     <= w_onehot;
                        r_valid <= 1'b1;
                        r_hold  <= '0;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    r_hold <= r_hold + 8'd1;
                    if (w_release) begin
                        r_y       <= '0;
                        r_valid   <= 1'b0;
                        r_state   <= S_IDLE;
                        // A pure disable leaves priority where it was.
                        if (w_advance)
                            r_ptr <= r_w + 4'd1;
                        r_timeout <= w_hold_exp && !done && !w_withdraw && !Enable;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign W       = r_w;
    assign Y       = r_y;
    assign valid   = r_valid;
    assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb16.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arb16
// Brief   : Self-checking bench for rr_arb16: directed scenarios plus random
//           traffic compared every cycle against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_rr_arb16;

    localparam int MAX_HOLD = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        Enable;
    logic [15:0] req;
    logic        done;
    logic [3:0]  W;
    logic [0:15] Y;
    logic        valid;
    logic        timeout;

    int n_err = 0;
    int n_chk = 0;

    // Model: owner is -1 when idle; held counts cycles valid has been high.
    int m_owner = -1;
    int m_ptr   = 0;
    int m_W     = 0;
    int m_held  = 0;
    bit m_to    = 1'b0;

    rr_arb16 #(.N_REQ(16), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .reset   (reset),
        .Enable  (Enable),
        .req     (req),
        .done    (done),
        .W       (W),
        .Y       (Y),
        .valid   (valid),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit a, b, c, d;
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (!Enable && req != 16'h0) begin
                for (int k = 0; k < 16; k++) begin
                    int i;
                    i = (m_ptr + k) % 16;
                    if (req[i] && m_owner < 0) begin
                        m_owner = i;
                        m_W     = i;
                        m_held  = 1;
                    end
                end
            end
        end else begin
            a = done;
            b = !req[m_owner];
            c = (m_held == MAX_HOLD);
            d = Enable;
            if (a || b || c || d) begin
                if (a || b || c)
                    m_ptr = (m_owner + 1) % 16;
                m_to    = c && !a && !b && !d;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    always @(posedge clk or posedge reset) begin
        logic [0:15] exp_y;
        if (reset) begin
            m_owner = -1;
            m_ptr   = 0;
            m_W     = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else begin
            model_step();
        end
        #1;
        exp_y = '0;
        for (int i = 0; i < 16; i++)
            if (i == m_owner) exp_y[i] = 1'b1;
        chk("model_W",       32'(W),       32'(m_W));
        chk("model_Y",       32'(Y),       32'(exp_y));
        chk("model_valid",   32'(valid),   32'(m_owner >= 0));
        chk("model_timeout", 32'(timeout), 32'(m_to));
    end

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        req    = '0;
        done   = 1'b0;
        Enable = 1'b0;
        @(negedge clk);
        reset  = 1'b0;
    endtask

    task automatic hold_run(input string name, input int exp_w);
        int n;
        n = 0;
        chk({name, "_W"}, 32'(W), 32'(exp_w));
        while (valid === 1'b1 && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_cycles"}, 32'(n), 32'(MAX_HOLD));
        chk({name, "_timeout"}, 32'(timeout), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        reset  = 1'b1;
        Enable = 1'b1;
        req    = '0;
        done   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_W", 32'(W), 32'd0);
        chk("rst_Y", 32'(Y), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset = 1'b0;

        // Asynchronous reset in the middle of a grant
        Enable = 1'b0;
        req    = 16'h0020;
        @(negedge clk);
        chk("t1_grant_W", 32'(W), 32'd5);
        chk("t1_grant_valid", 32'(valid), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("t1_async_W", 32'(W), 32'd0);
        chk("t1_async_Y", 32'(Y), 32'd0);
        chk("t1_async_valid", 32'(valid), 32'd0);
        req = 16'h0200;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t1_after_W", 32'(W), 32'd9);
        chk("t1_after_valid", 32'(valid), 32'd1);

        // Single request, done release, regrant after one idle cycle
        do_reset();
        req = 16'h0020;
        @(negedge clk);
        chk("t2_W", 32'(W), 32'd5);
        chk("t2_Y5", 32'(Y[5]), 32'd1);
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        chk("t2_rel_valid", 32'(valid), 32'd0);
        chk("t2_rel_timeout", 32'(timeout), 32'd0);
        chk("t2_rel_W", 32'(W), 32'd5);
        @(negedge clk);
        chk("t2_regrant_valid", 32'(valid), 32'd1);
        chk("t2_regrant_W", 32'(W), 32'd5);
        req = '0;
        @(negedge clk);
        chk("t2_withdraw_valid", 32'(valid), 32'd0);

        // Round-robin wrap with done held high
        do_reset();
        req  = 16'hFFFF;
        done = 1'b1;
        for (int g = 0; g < 18; g++) begin
            @(negedge clk);
            chk("t3_W", 32'(W), 32'(g % 16));
            chk("t3_valid", 32'(valid), 32'd1);
            @(negedge clk);
            chk("t3_gap", 32'(valid), 32'd0);
        end
        done = 1'b0;

        // Hold-limit expiry alternating between 3 and 9
        do_reset();
        req = 16'h0208;
        @(negedge clk);
        hold_run("t4_a", 3);
        chk("t4_b_start", 32'(valid), 32'd1);
        hold_run("t4_b", 9);
        chk("t4_c_W", 32'(W), 32'd3);
        chk("t4_c_valid", 32'(valid), 32'd1);

        // Enable control
        do_reset();
        Enable = 1'b1;
        req    = 16'hFFFF;
        repeat (5) begin
            @(negedge clk);
            chk("t5_disabled_valid", 32'(valid), 32'd0);
        end
        Enable = 1'b0;
        @(negedge clk);
        chk("t5_grant_W", 32'(W), 32'd0);
        Enable = 1'b1;
        @(negedge clk);
        chk("t5_drop_Y", 32'(Y), 32'd0);
        chk("t5_drop_timeout", 32'(timeout), 32'd0);
        Enable = 1'b0;
        @(negedge clk);
        chk("t5_regrant_W", 32'(W), 32'd0);
        chk("t5_regrant_valid", 32'(valid), 32'd1);

        // done + withdraw coinciding with hold expiry
        do_reset();
        req = 16'h0208;
        @(negedge clk);
        chk("t6_W", 32'(W), 32'd3);
        repeat (MAX_HOLD - 1) @(negedge clk);
        done = 1'b1;
        req  = 16'h0200;
        @(negedge clk);
        chk("t6_rel_valid", 32'(valid), 32'd0);
        chk("t6_rel_timeout", 32'(timeout), 32'd0);
        done = 1'b0;
        req  = 16'h0208;
        @(negedge clk);
        chk("t6_ptr_W", 32'(W), 32'd9);

        // Random traffic
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            if (reset)
                reset = 1'b0;
            else if ($urandom_range(0, 299) == 0)
                reset = 1'b1;
            Enable = ($urandom_range(0, 9) == 0);
            done   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'h0;
                    1: req = 16'h1 << $urandom_range(0, 15);
                    2: req = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
                    default: req = 16'($urandom);
                endcase
            end
        end
        reset = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
